// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the bus_slave block.
//   - FSM state encoding (legacy localparam constants)
//   - register index constants and counter widths
//   - WAIT_CYC legal range limit
package bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StAck  = 2'd2;
  localparam state_t StHold = 2'd3;

  localparam logic [1:0] REG0     = 2'd0;
  localparam logic [1:0] REG1     = 2'd1;
  localparam logic [1:0] REG2     = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int unsigned WaitCycMax = 15;
  localparam int unsigned WaitCntW   = 4;
  localparam int unsigned WrCntW     = 8;

  // True for the read/write data registers; the status register is read-only.
  function automatic logic is_rw_reg(logic [1:0] idx);
    return idx != REG_STAT;
  endfunction

endpackage

// File: rtl/bus_slave_regs.sv
// bus_slave_regs: register file behind bus_slave.
//   Three DATA_W-wide read/write registers plus a read-only status register
//   whose low byte counts committed writes (wraps 255 -> 0).
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   we_i     write commit strobe (one cycle)
//   addr_i   register index
//   wdata_i  write data
//   rdata_o  combinational read data for addr_i
module bus_slave_regs
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] reg0_q, reg0_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    reg0_d   = reg0_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    wr_cnt_d = wr_cnt_q;
    // Writes to the status register are accepted on the bus but dropped here.
    if (we_i && is_rw_reg(addr_i)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      unique case (addr_i)
        REG0:    reg0_d = wdata_i;
        REG1:    reg1_d = wdata_i;
        REG2:    reg2_d = wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg0_q   <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      reg0_q   <= reg0_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      REG0:     rdata_o = reg0_q;
      REG1:     rdata_o = reg1_q;
      REG2:     rdata_o = reg2_q;
      REG_STAT: rdata_o[WrCntW-1:0] = wr_cnt_q;
      default:  rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/sw.vh
// Shared signal-level constants for active-high control strobes.
`ifndef SW_VH
`define SW_VH
`define ASSERT 1'b1
`define NEGATE 1'b0
`endif

// File: rtl/bus_slave.sv
// bus_slave: simple strobe/ack bus slave with programmable wait states.
//   A request (cs & as in IDLE) latches addr/rw/wr_data, waits WAIT_CYC
//   cycles, then produces a one-cycle registered ack. Writes commit on the
//   edge leaving ACK. The master must drop as before another access starts.
// Ports:
//   clk      system clock (rising edge)
//   rst      synchronous active-low reset
//   cs       chip select, active-high
//   as       address strobe, active-high, held until ack is seen
//   rw       1 = read, 0 = write
//   addr     register index
//   wr_data  write data
//   rd_data  read data, non-zero only while ack is high
//   ack      one-cycle access-complete pulse
`include "sw.vh"

module bus_slave
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              as,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack
);

  // Out-of-range settings saturate at the largest legal wait.
  localparam int unsigned WaitLoad = (WAIT_CYC > WaitCycMax) ? WaitCycMax : WAIT_CYC;

  state_t              state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic [1:0]          addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                commit;
  logic [DATA_W-1:0]   reg_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (cs == `ASSERT && as == `ASSERT) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wr_data;
          if (WaitLoad == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = WaitCntW'(WaitLoad - 1);
          end
        end
      end
      StWait: begin
        // A dropped strobe abandons the access before anything is committed.
        if (as == `NEGATE) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        state_d = StHold;
      end
      StHold: begin
        // Wait for the strobe to fall so a held request is not taken twice.
        if (as == `NEGATE) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign commit = (state_q == StAck) && (rw_q == 1'b0);

  // ack and rd_data are registered: they are high in the cycle after ACK.
  always_comb begin
    ack_d     = `NEGATE;
    rd_data_d = '0;
    if (state_q == StAck) begin
      ack_d     = `ASSERT;
      rd_data_d = reg_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= `NEGATE;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  bus_slave_regs #(
    .DATA_W (DATA_W)
  ) u_regs (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (commit),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (reg_rdata)
  );

  assign ack     = ack_q;
  assign rd_data = rd_data_q;

endmodule

// File: doc/bus_slave.md
BUS_SLAVE -- requirements
Module: bus_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data bus width.
REQ-002 The block SHALL have parameter WAIT_CYC, default 2, the number of wait cycles before ack (legal range 0..15).
REQ-003 The block SHALL have port clk  input  1  the single system clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  the reset, synchronous and active-low.
REQ-005 The block SHALL have port cs  input  1  chip select from the address decoder, active-high (`ASSERT).
REQ-006 The block SHALL have port as  input  1  address strobe from the master, active-high, held by the master until it samples ack.
REQ-007 The block SHALL have port rw  input  1  access direction: 1 = read, 0 = write.
REQ-008 The block SHALL have port addr  input  2  register index.
REQ-009 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-010 The block SHALL have port rd_data  output  DATA_W  read data, valid only while ack is asserted, otherwise 0.
REQ-011 The block SHALL have port ack  output  1  one-cycle access-complete pulse, feeding the system ack OR tree.

Function
REQ-012 The block SHALL implement FSM states IDLE, WAIT, ACK and HOLD.
REQ-013 In IDLE, the block SHALL sample cs & as; when both are asserted, it SHALL latch addr, rw and wr_data.
  - If WAIT_CYC = 0 it SHALL go to ACK; otherwise it SHALL go to WAIT with the wait counter loaded to WAIT_CYC-1.
REQ-014 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to ACK.
REQ-015 Ack latency: for a request sampled at edge N, ack SHALL be high for exactly the cycle after edge N+1+WAIT_CYC.
REQ-016 In ACK, ack SHALL be asserted and rd_data SHALL equal the register addressed by the latched addr.
  - A write SHALL commit on the edge leaving ACK.
  - The next state SHALL be HOLD.
REQ-017 In HOLD, the block SHALL wait until as is negated, then go to IDLE; a held strobe SHALL NOT retrigger.
REQ-018 Abort: if as is negated while in WAIT, the FSM SHALL return to IDLE with no ack and no register write.
REQ-019 Register map:
  - Registers 0..2 are read/write, DATA_W wide.
  - Register 3 is read-only: bits [7:0] hold a write-completion counter, upper bits read 0.
REQ-020 A write to address 3 SHALL be acked but SHALL NOT change any register.
REQ-021 The write counter SHALL increment by 1 on each committed write to addresses 0..2 and SHALL wrap from 255 to 0.
REQ-022 Changes to addr, rw or wr_data after the request is latched SHALL have no effect on the access in progress.
REQ-023 If cs is negated while as is asserted in IDLE, the block SHALL ignore the request.

Reset
REQ-024 When rst = 0 at a rising clk edge, the block SHALL set FSM to IDLE, wait counter to 0, registers 0..2 to 0, write counter to 0, ack to `NEGATE and rd_data to 0.
REQ-025 A reset during WAIT, ACK or HOLD SHALL abort the access with no write commit and no ack in the following cycle.

Structure
REQ-026 The FSM state encoding, register index constants (REG0..REG2, REG_STAT) and the WAIT_CYC range limit SHALL reside in the shared package bus_pkg; `ASSERT/`NEGATE levels SHALL come from sw.vh.
REQ-027 The register file and write counter SHALL be one sub-module, bus_slave_regs; the FSM, wait counter and ack generation SHALL reside in bus_slave.

Verification
REQ-028 Scenario: reset, then write reg1 = 32'hDEADBEEF with WAIT_CYC=2 -> ack is high exactly 3 cycles after the request edge, for 1 cycle; reg3 reads 32'h1.
REQ-029 Scenario: read reg1 after that write -> rd_data = 32'hDEADBEEF during the ack cycle and 0 in the cycles before and after.
REQ-030 Scenario: master holds as for 5 cycles after ack -> exactly one ack pulse, no second write, write counter unchanged.
REQ-031 Scenario: as dropped after 1 wait cycle -> no ack, reg0 keeps its value, write counter unchanged.
REQ-032 Scenario: 256 writes to reg2 -> write counter returns to 0; a write to reg3 with 32'hFFFFFFFF -> ack, reg3 unchanged.
REQ-033 Scenario: rst = 0 asserted in WAIT of a write -> next cycle state is IDLE, ack = 0, target register still 0; with WAIT_CYC=0 -> ack appears 1 cycle after the request edge.
